// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute controller for the picoMIPS data path.
// Owns the program counter, drives the synchronous program ROM, decodes each
// instruction into data path controls and sequences the WAITP button handshake.
// Optional feature macro: SWITCH_DEBOUNCE_EN adds a stable-sample debouncer on
// the synchronized step button (switchesIn[8]); when undefined the FSM uses the
// two-flop synchronizer output directly.

package cpuConfig;
    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_MUL   = 2'd2,
        ALU_PASSB = 2'd3
    } aluFunc_t;
endpackage

module cpu_sequencer #(
    parameter int N               = 8,
    parameter int A_SIZE          = 3,
    parameter int R_SIZE          = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  nReset,
    output logic [A_SIZE-1:0]     progAddr,
    input  logic [4+R_SIZE+N-1:0] progData,
    input  logic [9:0]            switchesIn,
    output logic                  writeReg,
    output cpuConfig::aluFunc_t   aluFunc,
    output logic                  aluImmediate,
    output logic                  immSwitches,
    output logic [R_SIZE-1:0]     opD,
    output logic [R_SIZE-1:0]     opS,
    output logic [N-1:0]          opT,
    output logic                  halted,
    output logic                  illegal
);
    import cpuConfig::*;

    localparam int I = 4 + R_SIZE + N;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_MULI  = 4'h4;
    localparam logic [3:0] OP_LDSW  = 4'h5;
    localparam logic [3:0] OP_WAITP = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'h8;

    localparam logic [A_SIZE-1:0] PC_ONE = A_SIZE'(1);

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        WAIT_PRESS,
        WAIT_RELEASE,
        HALTED
    } state_t;

    state_t            state_reg;
    logic [A_SIZE-1:0] pc_reg;
    logic              halted_reg;
    logic              illegal_reg;
    logic [1:0]        sync_reg;
    logic              button;

    // Instruction fields are always taken straight from the ROM word.
    logic [3:0]        opcode;
    logic [R_SIZE-1:0] rd;
    logic [N-1:0]      imm;

    assign opcode = progData[I-1:I-4];
    assign rd     = progData[I-5:N];
    assign imm    = progData[N-1:0];

    assign progAddr = pc_reg;
    assign opD      = rd;
    assign opS      = imm[R_SIZE-1:0];
    assign opT      = imm;
    assign halted   = halted_reg;
    assign illegal  = illegal_reg;

    // Only the step button is consumed here; the other switch bits reach the
    // data path through its own immediate mux.
    logic unused_bits;
    assign unused_bits = (^{switchesIn[9], switchesIn[7:0]}) ^ (DEBOUNCE_CYCLES == 0);

    // Two-flop synchronizer for the asynchronous step button.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], switchesIn[8]};
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt_reg;
    logic             db_level_reg;

    // Debouncer: flip the level only after a run of samples that disagree with it.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b0;
        end else if (sync_reg[1] == db_level_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == CNT_LAST) begin
            db_cnt_reg   <= '0;
            db_level_reg <= sync_reg[1];
        end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
        end
    end

    assign button = db_level_reg;
`else
    assign button = sync_reg[1];
`endif

    // Control decode: active only while executing, safe defaults elsewhere.
    always_comb begin
        writeReg     = 1'b0;
        aluFunc      = ALU_ADD;
        aluImmediate = 1'b0;
        immSwitches  = 1'b0;
        if (state_reg == EXEC) begin
            case (opcode)
                OP_ADD: begin
                    writeReg = 1'b1;
                    aluFunc  = ALU_ADD;
                end
                OP_ADDI: begin
                    writeReg     = 1'b1;
                    aluFunc      = ALU_ADD;
                    aluImmediate = 1'b1;
                end
                OP_SUB: begin
                    writeReg = 1'b1;
                    aluFunc  = ALU_SUB;
                end
                OP_MULI: begin
                    writeReg     = 1'b1;
                    aluFunc      = ALU_MUL;
                    aluImmediate = 1'b1;
                end
                OP_LDSW: begin
                    writeReg     = 1'b1;
                    aluFunc      = ALU_PASSB;
                    aluImmediate = 1'b1;
                    immSwitches  = 1'b1;
                end
                default: begin
                    writeReg = 1'b0;
                end
            endcase
        end
    end

    // Sequencer FSM with PC and the sticky halted/illegal flags.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_reg   <= FETCH;
            pc_reg      <= '0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    state_reg <= EXEC;
                end
                EXEC: begin
                    case (opcode)
                        OP_WAITP: begin
                            state_reg <= WAIT_PRESS;
                        end
                        OP_JMP: begin
                            pc_reg    <= imm[A_SIZE-1:0];
                            state_reg <= FETCH;
                        end
                        OP_HALT: begin
                            halted_reg <= 1'b1;
                            state_reg  <= HALTED;
                        end
                        default: begin
                            // Register ops, NOP and undefined opcodes all step on.
                            pc_reg    <= pc_reg + PC_ONE;
                            state_reg <= FETCH;
                            if (opcode > OP_HALT) begin
                                illegal_reg <= 1'b1;
                            end
                        end
                    endcase
                end
                WAIT_PRESS: begin
                    if (button) begin
                        state_reg <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!button) begin
                        pc_reg    <= pc_reg + PC_ONE;
                        state_reg <= FETCH;
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    // OP_NOP needs no special handling; keep the name tied to the decode.
    logic unused_nop;
    assign unused_nop = (OP_NOP == 4'h0);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a behavioural ROM, a scoreboard of
// expected register writes, and one task per scenario.
module tb_cpu_sequencer;
    import cpuConfig::*;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [2:0]  progAddr;
    logic [14:0] progData = '0;
    logic [9:0]  switchesIn = '0;
    logic        writeReg;
    aluFunc_t    aluFunc;
    logic        aluImmediate;
    logic        immSwitches;
    logic [2:0]  opD;
    logic [2:0]  opS;
    logic [7:0]  opT;
    logic        halted;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        aluFunc_t   func;
        logic       aimm;
        logic       isw;
        logic [2:0] d;
        logic [2:0] s;
        logic [7:0] t;
    } wr_t;

    wr_t exp_q[$];
    logic [14:0] rom [0:7];

    cpu_sequencer #(.N(8), .A_SIZE(3), .R_SIZE(3), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .nReset(nReset), .progAddr(progAddr), .progData(progData),
        .switchesIn(switchesIn), .writeReg(writeReg), .aluFunc(aluFunc),
        .aluImmediate(aluImmediate), .immSwitches(immSwitches),
        .opD(opD), .opS(opS), .opT(opT), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word valid the cycle after the address.
    always @(posedge clk) progData <= rom[progAddr];

    function automatic logic [14:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    // Scoreboard: every observed write pops and compares one expectation.
    always @(negedge clk) begin
        if (writeReg === 1'b1) begin
            wr_t act;
            wr_t e;
            act = '{func: aluFunc, aimm: aluImmediate, isw: immSwitches, d: opD, s: opS, t: opT};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got=%h required=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL write got=%h required=%h", act, e);
                end else begin
                    $display("write ok func=%0d d=%0d s=%0d t=%h", act.func, act.d, act.s, act.t);
                end
            end
        end
    end

    task automatic fill_rom(input logic [14:0] w);
        for (int i = 0; i < 8; i++) rom[i] = w;
    endtask

    // Hold reset for two cycles, then release at a falling edge.
    task automatic run_reset();
        nReset = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = 15'($urandom);
        repeat (2) @(negedge clk);
        checks++;
        if ({progAddr, writeReg, halted, illegal, aluImmediate, immSwitches} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state got=%b required=%b",
                     {progAddr, writeReg, halted, illegal, aluImmediate, immSwitches}, 8'b0);
        end
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        @(negedge clk);
        nReset = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (halted !== (c == 2)) begin
                errors++;
                $display("FAIL reset_first_exec cycle=%0d halted got=%b required=%b", c, halted, c == 2);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_alu();
        nReset = 1'b0;
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        rom[0] = enc(4'h2, 3'd1, 8'h05);
        rom[1] = enc(4'h3, 3'd1, 8'h01);
        rom[2] = enc(4'h4, 3'd3, 8'hF7);
        rom[3] = enc(4'h1, 3'd2, 8'h2B);
        exp_q.push_back('{func: ALU_ADD, aimm: 1'b1, isw: 1'b0, d: 3'd1, s: 3'd5, t: 8'h05});
        exp_q.push_back('{func: ALU_SUB, aimm: 1'b0, isw: 1'b0, d: 3'd1, s: 3'd1, t: 8'h01});
        exp_q.push_back('{func: ALU_MUL, aimm: 1'b1, isw: 1'b0, d: 3'd3, s: 3'd7, t: 8'hF7});
        exp_q.push_back('{func: ALU_ADD, aimm: 1'b0, isw: 1'b0, d: 3'd2, s: 3'd3, t: 8'h2B});
        run_reset();
        for (int c = 1; c <= 12; c++) begin
            logic exp_wr;
            @(negedge clk);
            exp_wr = (c % 2 == 1) && (c <= 7);
            checks++;
            if (writeReg !== exp_wr) begin
                errors++;
                $display("FAIL alu_writeReg cycle=%0d got=%b required=%b", c, writeReg, exp_wr);
            end
            if (c == 2) begin
                checks++;
                if (aluFunc !== ALU_ADD || aluImmediate !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_fetch_defaults got=%0d/%b required=%0d/0", aluFunc, aluImmediate, ALU_ADD);
                end
            end
            if (c == 9) begin
                checks++;
                if (progAddr !== 3'd4) begin
                    errors++;
                    $display("FAIL alu_pc got=%0d required=4", progAddr);
                end
            end
        end
        $display("test_alu done");
    endtask

    task automatic test_ldsw();
        nReset = 1'b0;
        switchesIn = 10'h0A5;
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        rom[0] = enc(4'h5, 3'd2, 8'h00);
        exp_q.push_back('{func: ALU_PASSB, aimm: 1'b1, isw: 1'b1, d: 3'd2, s: 3'd0, t: 8'h00});
        run_reset();
        @(negedge clk);
        begin
            logic [7:0] b_operand;
            b_operand = immSwitches ? switchesIn[7:0] : opT;
            checks++;
            if (b_operand !== 8'hA5) begin
                errors++;
                $display("FAIL ldsw_operand got=%h required=a5", b_operand);
            end
        end
        @(negedge clk);
        checks++;
        if (immSwitches !== 1'b0) begin
            errors++;
            $display("FAIL ldsw_immSwitches_fetch got=%b required=0", immSwitches);
        end
        repeat (3) @(negedge clk);
        switchesIn = '0;
        $display("test_ldsw done");
    endtask

    task automatic test_waitp();
        nReset = 1'b0;
        switchesIn = '0;
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        rom[0] = enc(4'h6, 3'd0, 8'h00);
        rom[1] = enc(4'h0, 3'd0, 8'h00);
        rom[2] = enc(4'h6, 3'd0, 8'h00);
        run_reset();
        for (int c = 1; c <= 23; c++) begin
            logic [2:0] exp_pc;
            @(negedge clk);
            exp_pc = (c <= 11) ? 3'd0 : (c <= 13) ? 3'd1 : (c <= 20) ? 3'd2 : 3'd3;
            checks++;
            if (progAddr !== exp_pc || writeReg !== 1'b0) begin
                errors++;
                $display("FAIL waitp cycle=%0d pc got=%0d required=%0d writeReg got=%b required=0",
                         c, progAddr, exp_pc, writeReg);
            end
            switchesIn[8] = ((c >= 6) && (c < 9)) || ((c >= 12) && (c < 18));
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL waitp_halt got=%b required=1", halted);
        end
        $display("test_waitp done");
    endtask

    task automatic test_wrap_jmp();
        logic [2:0] exp_pc [1:8];
        exp_pc = '{3'd0, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0, 3'd0, 3'd5};
        nReset = 1'b0;
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        rom[0] = enc(4'h7, 3'd0, 8'h0D);
        rom[5] = enc(4'h7, 3'd0, 8'h0F);
        rom[7] = enc(4'h0, 3'd0, 8'h00);
        run_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (progAddr !== exp_pc[c] || writeReg !== 1'b0) begin
                errors++;
                $display("FAIL wrap_jmp cycle=%0d pc got=%0d required=%0d writeReg=%b",
                         c, progAddr, exp_pc[c], writeReg);
            end
        end
        $display("test_wrap_jmp done");
    endtask

    task automatic test_halt_illegal();
        nReset = 1'b0;
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        rom[0] = enc(4'h2, 3'd4, 8'h03);
        exp_q.push_back('{func: ALU_ADD, aimm: 1'b1, isw: 1'b0, d: 3'd4, s: 3'd3, t: 8'h03});
        run_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (halted !== (c >= 4) || progAddr !== ((c == 1) ? 3'd0 : 3'd1)) begin
                errors++;
                $display("FAIL halt cycle=%0d halted got=%b required=%b pc got=%0d",
                         c, halted, c >= 4, progAddr);
            end
        end
        nReset = 1'b0;
        fill_rom(enc(4'h8, 3'd0, 8'h00));
        rom[0] = enc(4'hB, 3'd1, 8'h11);
        rom[1] = enc(4'hF, 3'd2, 8'h22);
        repeat (2) @(negedge clk);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset got=%b required=0", halted);
        end
        nReset = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (illegal !== (c >= 2) || writeReg !== 1'b0 || progAddr !== ((c == 1) ? 3'd0 : (c <= 3) ? 3'd1 : 3'd2)) begin
                errors++;
                $display("FAIL illegal cycle=%0d illegal got=%b required=%b pc got=%0d writeReg=%b",
                         c, illegal, c >= 2, progAddr, writeReg);
            end
        end
        nReset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset got=%b required=0", illegal);
        end
        $display("test_halt_illegal done");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ldsw();
        test_waitp();
        test_wrap_jmp();
        test_halt_illegal();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
